// File: rtl/rej_uniform_sampler_pkg.sv
// Shared Kyber constants, state encoding and candidate helper for the uniform sampler.
package rej_uniform_sampler_pkg;

  localparam int unsigned BW_DATA    = 64;
  localparam int unsigned BW_COEF    = 12;
  localparam int unsigned KYBER_Q    = 3329;
  localparam int unsigned KYBER_N    = 256;
  localparam int unsigned BUF_BYTES  = 16;
  localparam int unsigned DATA_BYTES = BW_DATA / 8;
  localparam int unsigned BW_IDX     = $clog2(KYBER_N);
  localparam int unsigned BW_CNT     = $clog2(BUF_BYTES + 1);
  localparam int unsigned BW_PTR     = $clog2(BUF_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [BW_IDX-1:0]  idx;
    logic [BW_COEF-1:0] coef;
  } coef_t;

  // Two 12-bit candidates per 3-byte group, little-endian nibble packing.
  function automatic logic [BW_COEF-1:0] cand_extract(input logic       phase,
                                                      input logic [7:0] b0,
                                                      input logic [7:0] b1,
                                                      input logic [7:0] b2);
    return phase ? {b2, b1[7:4]} : {b1[3:0], b0};
  endfunction

endpackage

// File: rtl/rej_byte_buf.sv
// Byte shift buffer: 8-byte append behind current contents, 3-byte pop from the head.
module rej_byte_buf
  import rej_uniform_sampler_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    clr,
  input  logic                    push,
  input  logic [BW_DATA-1:0]      push_data,
  input  logic                    pop,
  output logic [2:0][7:0]         head,
  output logic [BW_CNT-1:0]       count,
  output logic [BW_CNT-1:0]       count_nxt
);

  logic [7:0]        mem_q   [BUF_BYTES];
  logic [7:0]        mem_nxt [BUF_BYTES];
  logic [BW_CNT-1:0] count_q;
  logic [BW_CNT-1:0] cnt_base;
  logic [BW_CNT-1:0] wr_idx;

  // Pop shifts first, then the new word lands right after the surviving bytes.
  always_comb begin
    mem_nxt  = mem_q;
    cnt_base = count_q;
    wr_idx   = '0;
    if (pop) begin
      for (int i = 0; i < BUF_BYTES - 3; i++) mem_nxt[i] = mem_q[i+3];
      for (int i = BUF_BYTES - 3; i < BUF_BYTES; i++) mem_nxt[i] = '0;
      cnt_base = count_q - BW_CNT'(3);
    end
    if (push) begin
      for (int j = 0; j < DATA_BYTES; j++) begin
        wr_idx = cnt_base + BW_CNT'(j);
        if (wr_idx < BW_CNT'(BUF_BYTES))
          mem_nxt[wr_idx[BW_PTR-1:0]] = push_data[BW_DATA-1-8*j -: 8];
      end
    end
    count_nxt = clr  ? '0 :
                push ? cnt_base + BW_CNT'(DATA_BYTES) : cnt_base;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mem_q   <= '{default: '0};
      count_q <= '0;
    end else begin
      mem_q   <= mem_nxt;
      count_q <= count_nxt;
    end
  end

  assign head[0] = mem_q[0];
  assign head[1] = mem_q[1];
  assign head[2] = mem_q[2];
  assign count   = count_q;

endmodule

// File: rtl/rej_uniform_sampler.sv
// Kyber SampleNTT rejection sampler fed by the SHAKE128 keccak byte stream.
module rej_uniform_sampler
  import rej_uniform_sampler_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [BW_DATA-1:0] i_ibytes,
  input  logic               i_ibytes_valid,
  output logic               o_ibytes_ready,
  output logic [BW_COEF-1:0] o_coef,
  output logic [BW_IDX-1:0]  o_coef_idx,
  output logic               o_coef_valid,
  output logic               o_busy,
  output logic               o_done
);

  state_e             state_q, state_nxt;
  logic               phase_q, phase_nxt;
  logic [BW_IDX-1:0]  cnt_q, cnt_nxt;
  logic [BW_COEF-1:0] cand_q, cand_nxt;
  logic               cand_vld_q, cand_vld_nxt;
  coef_t              out_q, out_nxt;
  logic               out_vld_q, out_vld_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic               ready_q, ready_nxt;

  logic               buf_clr, buf_push, buf_pop;
  logic [2:0][7:0]    buf_head;
  logic [BW_CNT-1:0]  buf_count, buf_count_nxt;
  logic               accept, last;

  rej_byte_buf u_buf (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .clr       (buf_clr),
    .push      (buf_push),
    .push_data (i_ibytes),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count),
    .count_nxt (buf_count_nxt)
  );

  assign buf_push = i_ibytes_valid && ready_q;
  assign accept   = (state_q == ST_RUN) && cand_vld_q && (cand_q < BW_COEF'(KYBER_Q));
  assign last     = accept && (cnt_q == BW_IDX'(KYBER_N - 1));

  // Stage 1 extracts a candidate from the buffer head, stage 2 compares and emits it.
  always_comb begin
    state_nxt    = state_q;
    phase_nxt    = phase_q;
    cnt_nxt      = cnt_q;
    cand_nxt     = cand_q;
    cand_vld_nxt = 1'b0;
    out_nxt      = out_q;
    out_vld_nxt  = 1'b0;
    buf_clr      = 1'b0;
    buf_pop      = 1'b0;

    if (i_start) begin
      state_nxt = ST_RUN;
      phase_nxt = 1'b0;
      cnt_nxt   = '0;
      buf_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_RUN: begin
          if (accept) begin
            out_nxt     = '{idx: cnt_q, coef: cand_q};
            out_vld_nxt = 1'b1;
            cnt_nxt     = cnt_q + BW_IDX'(1);
          end
          if (last) begin
            // Leftover bytes and the in-flight d2 belong to no polynomial.
            state_nxt = ST_DONE;
            phase_nxt = 1'b0;
            buf_clr   = 1'b1;
          end else if (buf_count >= BW_CNT'(3)) begin
            cand_nxt     = cand_extract(phase_q, buf_head[0], buf_head[1], buf_head[2]);
            cand_vld_nxt = 1'b1;
            phase_nxt    = ~phase_q;
            buf_pop      = phase_q;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end

    busy_nxt  = (state_nxt == ST_RUN);
    done_nxt  = (state_q == ST_DONE) && !i_start;
    ready_nxt = (state_nxt == ST_RUN) &&
                (buf_count_nxt <= BW_CNT'(BUF_BYTES - DATA_BYTES));
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      phase_q    <= phase_nxt;
      cnt_q      <= cnt_nxt;
      cand_q     <= cand_nxt;
      cand_vld_q <= cand_vld_nxt;
      out_q      <= out_nxt;
      out_vld_q  <= out_vld_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      ready_q    <= ready_nxt;
    end
  end

  assign o_coef         = out_q.coef;
  assign o_coef_idx     = out_q.idx;
  assign o_coef_valid   = out_vld_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_ibytes_ready = ready_q;

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// Scoreboard bench for rej_uniform_sampler: directed words plus a byte-stream Parse model.
module tb_rej_uniform_sampler;

  typedef struct packed {
    logic [7:0]  idx;
    logic [11:0] coef;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_start;
  logic [63:0] i_ibytes;
  logic        i_ibytes_valid;
  logic        o_ibytes_ready;
  logic [11:0] o_coef;
  logic [7:0]  o_coef_idx;
  logic        o_coef_valid;
  logic        o_busy;
  logic        o_done;

  exp_t       exp_q[$];
  logic [7:0] byte_q[$];
  int         exp_n    = 0;
  int         last_idx = -1;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_done   = 0;
  bit         bp_seen  = 1'b0;
  bit         prev_last = 1'b0;

  rej_uniform_sampler dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_start        (i_start),
    .i_ibytes       (i_ibytes),
    .i_ibytes_valid (i_ibytes_valid),
    .o_ibytes_ready (o_ibytes_ready),
    .o_coef         (o_coef),
    .o_coef_idx     (o_coef_idx),
    .o_coef_valid   (o_coef_valid),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic void push_exp(input logic [11:0] d);
    exp_t e;
    e.idx  = 8'(exp_n);
    e.coef = d;
    exp_q.push_back(e);
    exp_n++;
  endfunction

  // Parse reference: whole 3-byte groups only, stop at 256 coefficients.
  function automatic void model_word(input logic [63:0] w);
    logic [7:0]  b0, b1, b2;
    logic [11:0] d1, d2;
    for (int j = 0; j < 8; j++) byte_q.push_back(w[63-8*j -: 8]);
    while (byte_q.size() >= 3 && exp_n < 256) begin
      b0 = byte_q.pop_front();
      b1 = byte_q.pop_front();
      b2 = byte_q.pop_front();
      d1 = {b1[3:0], b0};
      d2 = {b2, b1[7:4]};
      if (d1 < 12'd3329) push_exp(d1);
      if (exp_n < 256 && d2 < 12'd3329) push_exp(d2);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [63:0] w, input bit mdl);
    int n = 0;
    i_ibytes       = w;
    i_ibytes_valid = 1'b1;
    while (!o_ibytes_ready && n < 200) begin
      @(negedge i_clk);
      n++;
      bp_seen = 1'b1;
    end
    if (!o_ibytes_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: ready=%0b after %0d cycles, required 1", o_ibytes_ready, n);
    end else if (mdl) begin
      model_word(w);
    end
    @(negedge i_clk);
    i_ibytes_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_ibytes_valid = 1'b0;
    i_start        = 1'b1;
    exp_q.delete();
    byte_q.delete();
    exp_n    = 0;
    last_idx = -1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    repeat (6) @(negedge i_clk);
  endtask

  task automatic wait_idx(input int k);
    int n = 0;
    while (last_idx < k && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    chk("reach_idx", 32'(last_idx >= k), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_coef_valid), 32'd0);
    chk({tag, "_coef"},  32'(o_coef),       32'd0);
    chk({tag, "_idx"},   32'(o_coef_idx),   32'd0);
    chk({tag, "_busy"},  32'(o_busy),       32'd0);
    chk({tag, "_done"},  32'(o_done),       32'd0);
    chk({tag, "_ready"}, 32'(o_ibytes_ready), 32'd0);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always begin
    exp_t e;
    @(posedge i_clk);
    #1;
    if (prev_last) begin
      chk("done_after_last", 32'(o_done), 32'd1);
      chk("ready_after_last", 32'(o_ibytes_ready), 32'd0);
    end else if (o_done !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL spurious_done: o_done=%0b, required 0", o_done);
    end
    if (o_done === 1'b1) n_done++;
    if (o_coef_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_coef: idx=%0d coef=%0d, required no valid", o_coef_idx, o_coef);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (o_coef_idx !== e.idx || o_coef !== e.coef) begin
          n_fail++;
          $display("FAIL coef: idx=%0d coef=%0d, required idx=%0d coef=%0d",
                   o_coef_idx, o_coef, e.idx, e.coef);
        end
      end
      last_idx = int'(o_coef_idx);
    end
    prev_last = (o_coef_valid === 1'b1) && (o_coef_idx == 8'd255);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rstn         = 1'b0;
    i_start        = 1'b0;
    i_ibytes       = '0;
    i_ibytes_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    i_rstn = 1'b1;
    @(negedge i_clk);
    chk("idle_ready", 32'(o_ibytes_ready), 32'd0);

    // Basic decode: 0x201, 0x030, FFF group rejected, then zeros.
    pulse_start();
    chk("start_busy", 32'(o_busy), 32'd1);
    chk("start_ready", 32'(o_ibytes_ready), 32'd1);
    push_exp(12'd513);
    push_exp(12'd48);
    repeat (6) push_exp(12'd0);
    send(64'h010203_FFFFFF_0000, 1'b0);
    send(64'h0, 1'b0);
    wait_empty("basic_drain");

    // Restart around idx 100, then boundary values around Q.
    pulse_start();
    while (exp_n < 101) send(64'h0, 1'b1);
    wait_idx(100);
    pulse_start();
    chk("restart_no_valid", 32'(o_coef_valid), 32'd0);
    push_exp(12'd0);
    push_exp(12'd3328);
    push_exp(12'd3328);
    send(64'h010D00_000DD0_FFFF, 1'b0);
    wait_empty("boundary_drain");

    // Back-pressure: words offered back to back.
    pulse_start();
    bp_seen = 1'b0;
    for (int i = 0; i < 24; i++)
      send({32'(i * 32'h9E3779B9), 32'(i * 32'h85EBCA6B + 32'd7)}, 1'b1);
    chk("backpressure_seen", 32'(bp_seen), 32'd1);
    wait_empty("bp_drain");

    // Termination: exactly 256 zeros from 48 zero words.
    pulse_start();
    n_done = 0;
    for (int i = 0; i < 48; i++) send(64'h0, 1'b1);
    wait_empty("term_drain");
    chk("term_done_pulses", 32'(n_done), 32'd1);
    chk("term_ready", 32'(o_ibytes_ready), 32'd0);
    chk("term_busy", 32'(o_busy), 32'd0);

    // Counter restarts from 0.
    pulse_start();
    push_exp(12'd513);
    push_exp(12'd48);
    send(64'h010203_FFFFFF_0000, 1'b0);
    wait_empty("restart_drain");

    // Async reset mid-run.
    pulse_start();
    for (int i = 0; i < 4; i++) send(64'h0, 1'b1);
    wait_idx(10);
    i_rstn = 1'b0;
    exp_q.delete();
    byte_q.delete();
    #1;
    chk_all_zero("async_rst");
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (10) @(negedge i_clk);
    chk("post_rst_busy", 32'(o_busy), 32'd0);
    chk("post_rst_ready", 32'(o_ibytes_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rej_uniform_sampler.md
Name: rej_uniform_sampler

Overview:
Uniform rejection sampler for Kyber matrix-A generation (SampleNTT/Parse). It sits directly downstream of keccak running in SHAKE128 mode. It consumes keccak's 64-bit output word stream, splits it into 3-byte groups, and forms two 12-bit candidates per group. Candidates below Q are emitted as polynomial coefficients with an index, until N coefficients have been produced.

Parameters:
BW_DATA, 64, input word width (matches keccak output word)
BW_COEF, 12, coefficient width
KYBER_Q, 3329, rejection bound (accept when d < Q)
KYBER_N, 256, coefficients per polynomial
BUF_BYTES, 16, internal byte-buffer depth

Ports:
i_clk  input  1  clock
i_rstn  input  1  asynchronous, active-low reset
i_start  input  1  one-cycle pulse: clear state and begin a new polynomial
i_ibytes  input  64  keccak output word; first stream byte = [63:56], last = [7:0]
i_ibytes_valid  input  1  i_ibytes valid (driven from keccak o_obytes_valid)
o_ibytes_ready  output  1  sampler accepts a word this cycle
o_coef  output  12  accepted coefficient
o_coef_idx  output  8  coefficient index 0..N-1
o_coef_valid  output  1  o_coef/o_coef_idx valid, one cycle per coefficient
o_busy  output  1  state is RUN
o_done  output  1  one-cycle pulse after coefficient N-1

Behaviour:
- Reset: state IDLE; buffer count 0; phase 0; coefficient counter 0; o_coef=0, o_coef_idx=0, o_coef_valid=0, o_busy=0, o_done=0, o_ibytes_ready=0.
- States:
  - IDLE: on i_start go to RUN.
  - RUN: on the edge that accepts coefficient N-1, go to DONE.
  - DONE: lasts 1 cycle with o_done=1, then go to IDLE.
- i_start in RUN or DONE restarts the polynomial: buffer, phase and counter are cleared and the state becomes RUN. No coefficient valid is issued in that cycle.
- Input handshake:
  - A word transfers on an edge where i_ibytes_valid && o_ibytes_ready.
  - o_ibytes_ready = (state==RUN) && (byte count <= BUF_BYTES-8). It is derived from registered state only and never depends on i_ibytes_valid.
  - Accepted bytes are appended behind the existing buffer contents in stream order.
- Candidate extraction happens in RUN when byte count >= 3, with bytes b0,b1,b2 at the buffer head:
  - Phase 0: evaluate d1 = {b1[3:0], b0}, then set phase to 1.
  - Phase 1: evaluate d2 = {b2, b1[7:4]}, pop 3 bytes, then set phase to 0.
  - If d < KYBER_Q, the coefficient is registered. On the next cycle o_coef=d, o_coef_idx=counter, o_coef_valid=1, and the counter increments.
  - If d >= KYBER_Q, nothing is emitted and the counter holds.
- Pop and push may occur on the same edge. The new byte count is count - 3 + 8, and the ordering rule is pop first, then append.
- Latency: a word accepted at edge t with an empty buffer is evaluated in the cycle after t. Its d1 coefficient is valid after edge t+2.
- Throughput: one candidate per cycle, so 8 bytes per 5.33 cycles.
- Termination:
  - After coefficient N-1 is accepted, remaining buffered bytes and a pending d2 are discarded and the buffer is cleared.
  - o_ibytes_ready goes low from the next cycle.
- The counter never wraps: exactly N o_coef_valid pulses per polynomial.
- Starvation: with count < 3 in RUN, the block idles and waits indefinitely. Upstream is responsible for squeezing enough output (e.g. 504 bytes, then more blocks if needed).
- Async reset mid-operation aborts immediately to reset values. The next polynomial needs i_start.

Decomposition:
- Shared kyber package holds KYBER_Q, KYBER_N, BW_COEF, and BW_DATA (shared with keccak).
- Natural sub-module: rej_byte_buf, a BUF_BYTES-deep byte shift buffer with 8-byte push, 3-byte pop and a count output.
- Top level holds the FSM, phase, candidate compare and coefficient counter.

Test Plan:
- Basic decode: after i_start, feed 64'h010203_FFFFFF_0000 then 64'h00_00000000000000. Required output: idx0=513 (0x201), idx1=48 (0x030). The FFFFFF group produces no output, and the 00 00 00 groups produce zeros from idx2 onward.
- Boundary: feed a word whose first group is 01 0D 00. d1=3329 is rejected, d2=0 is accepted at idx0. A group 00 0D D0 gives d1=3328 (accepted) and d2=3328 (accepted).
- Termination: stream all-zero words. Required: exactly 256 valids (idx 0..255), o_done one cycle after idx255, o_ibytes_ready low thereafter, and the counter back to 0 after the next i_start.
- Back-pressure: hold i_ibytes_valid=1 continuously. o_ibytes_ready must deassert whenever count > 8, and no word may be lost or duplicated. Check against a SHAKE128 golden vector in the keccak vec format.
- Restart/reset: pulse i_start at idx 100. Required: the next valid is idx0 from newly fed data. Assert i_rstn low mid-RUN: all outputs 0 immediately, and no valid until i_start.
